// File: rtl/upower_mc_controller.sv
// Multi-cycle control FSM for the uPower core: sequences fetch/decode/execute/
// memory/writeback, drives datapath enables and counts retired instructions.
module upower_mc_controller #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_op_en,
  output logic             alu_src_imm,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             halted,
  output logic             illegal,
  output logic             bus_error,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

  localparam logic [2:0] C_ALU_R = 3'd0, C_ALU_I = 3'd1, C_LOAD = 3'd2, C_STORE = 3'd3,
                         C_BR = 3'd4, C_BC = 3'd5, C_SYS = 3'd6, C_ILL = 3'd7;

  localparam int WW = $clog2(MEM_TIMEOUT) + 1;

  function automatic logic [2:0] classify(input logic [5:0] op);
    case (op)
      6'd31:                            return C_ALU_R;
      6'd14, 6'd15, 6'd24, 6'd26, 6'd28: return C_ALU_I;
      6'd32, 6'd34, 6'd40, 6'd58:       return C_LOAD;
      6'd36, 6'd38, 6'd44, 6'd62:       return C_STORE;
      6'd18:                            return C_BR;
      6'd16:                            return C_BC;
      6'd17:                            return C_SYS;
      default:                          return C_ILL;
    endcase
  endfunction

  logic [2:0]    cls_q, dec_cls, nxt;
  logic [WW-1:0] wait_q;
  logic          waiting, timeout, retire;

  assign dec_cls = classify(opcode);
  assign waiting = (state == S_FETCH) || (state == S_MEM);
  // mem_ready on the last allowed cycle completes the request instead of erroring
  assign timeout = waiting && !mem_ready && (wait_q == WW'(MEM_TIMEOUT - 1));
  assign halted  = (state == S_HALT);

  always_comb begin
    nxt    = state;
    retire = 1'b0;
    case (state)
      S_IDLE:   if (start) nxt = S_FETCH;
      S_FETCH:  if (mem_ready) nxt = S_DECODE; else if (timeout) nxt = S_HALT;
      S_DECODE: begin
        if (dec_cls == C_ILL) nxt = S_HALT;
        else if (dec_cls == C_SYS) begin
          nxt    = S_HALT;
          retire = 1'b1;
        end else nxt = S_EXEC;
      end
      S_EXEC: begin
        case (cls_q)
          C_BR, C_BC: begin
            nxt    = S_FETCH;
            retire = 1'b1;
          end
          C_LOAD, C_STORE: nxt = S_MEM;
          default:         nxt = S_WB;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          nxt    = (cls_q == C_STORE) ? S_FETCH : S_WB;
          retire = (cls_q == C_STORE);
        end else if (timeout) nxt = S_HALT;
      end
      S_WB: begin
        nxt    = S_FETCH;
        retire = 1'b1;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cls_q       <= C_ALU_R;
      wait_q      <= '0;
      illegal     <= 1'b0;
      bus_error   <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= nxt;
      if (state == S_DECODE) cls_q <= dec_cls;
      if ((nxt == S_FETCH || nxt == S_MEM) && nxt != state) wait_q <= '0;
      else if (waiting && !mem_ready) wait_q <= wait_q + 1'b1;
      if (state == S_DECODE && dec_cls == C_ILL) illegal <= 1'b1;
      if (timeout) bus_error <= 1'b1;
      if (retire && instr_count != {CNT_W{1'b1}}) instr_count <= instr_count + 1'b1;
    end
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    alu_op_en    = 1'b0;
    alu_src_imm  = 1'b0;
    reg_write    = 1'b0;
    mem_to_reg   = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req  = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_EXEC: begin
        alu_op_en   = 1'b1;
        alu_src_imm = (cls_q == C_ALU_I) || (cls_q == C_LOAD) || (cls_q == C_STORE);
        if (cls_q == C_BR) begin
          pc_write = 1'b1;
          pc_src   = 1'b1;
        end else if (cls_q == C_BC) begin
          pc_write = branch_taken;
          pc_src   = 1'b1;
        end
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == C_STORE);
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (cls_q == C_LOAD);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_upower_mc_controller.sv
// Random-program scoreboard bench for upower_mc_controller plus directed
// reset / illegal / timeout / saturation scenarios.
module tb_upower_mc_controller;

  logic clock = 1'b0;
  logic reset_n, start, branch_taken, mem_ready;
  logic [5:0] opcode;

  logic a_mem_req, a_mem_we, a_mem_addr_sel, a_ir_write, a_pc_write, a_pc_src;
  logic a_alu_op_en, a_alu_src_imm, a_reg_write, a_mem_to_reg, a_halted, a_illegal, a_bus_error;
  logic [2:0]  a_state;
  logic [31:0] a_count;
  logic b_mem_req, b_mem_we, b_mem_addr_sel, b_ir_write, b_pc_write, b_pc_src;
  logic b_alu_op_en, b_alu_src_imm, b_reg_write, b_mem_to_reg, b_halted, b_illegal, b_bus_error;
  logic [2:0]  b_state;
  logic [3:0]  b_count;

  always #5 clock = ~clock;

  upower_mc_controller #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_addr_sel(a_mem_addr_sel),
    .ir_write(a_ir_write), .pc_write(a_pc_write), .pc_src(a_pc_src),
    .alu_op_en(a_alu_op_en), .alu_src_imm(a_alu_src_imm), .reg_write(a_reg_write),
    .mem_to_reg(a_mem_to_reg), .state(a_state), .halted(a_halted),
    .illegal(a_illegal), .bus_error(a_bus_error), .instr_count(a_count));

  // narrow-counter copy sharing all inputs, used for saturation
  upower_mc_controller #(.CNT_W(4), .MEM_TIMEOUT(16)) dut_sat (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_addr_sel(b_mem_addr_sel),
    .ir_write(b_ir_write), .pc_write(b_pc_write), .pc_src(b_pc_src),
    .alu_op_en(b_alu_op_en), .alu_src_imm(b_alu_src_imm), .reg_write(b_reg_write),
    .mem_to_reg(b_mem_to_reg), .state(b_state), .halted(b_halted),
    .illegal(b_illegal), .bus_error(b_bus_error), .instr_count(b_count));

  typedef struct packed {
    logic [7:0] k;
    logic       a;
    logic       b;
  } ev_t;

  typedef struct {
    logic [5:0] op;
    logic       taken;
  } instr_t;

  ev_t    exp_q[$];
  instr_t prog[$];
  int     checks = 0, errors = 0;
  logic   mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic cmp_ev(input string nm, input ev_t got);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event %s a=%0b b=%0b", nm, got.k, got.a, got.b);
    end else begin
      e = exp_q.pop_front();
      if (e !== got) begin
        errors++;
        $display("FAIL %s: got %s/%0b/%0b expected %s/%0b/%0b", nm, got.k, got.a, got.b,
                 e.k, e.a, e.b);
      end
    end
  endtask

  // Monitor: every visible datapath action becomes an event compared in order.
  always @(negedge clock) begin
    if (mon_en) begin
      if (a_mem_req && mem_ready) cmp_ev("mem_handshake", '{"M", a_mem_addr_sel, a_mem_we});
      if (a_alu_op_en)            cmp_ev("alu_exec", '{"X", a_alu_src_imm, 1'b0});
      if (a_pc_write)             cmp_ev("pc_write", '{"P", a_pc_src, 1'b0});
      if (a_reg_write)            cmp_ev("reg_write", '{"W", a_mem_to_reg, 1'b0});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    start   = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  // Reference model: instruction class -> ordered list of datapath actions.
  task automatic gen_instr(input int c, output instr_t ins);
    int alu_i[5] = '{14, 15, 24, 26, 28};
    int ld[4]    = '{32, 34, 40, 58};
    int st[4]    = '{36, 38, 44, 62};
    ins.taken = 1'($urandom_range(0, 1));
    exp_q.push_back('{"M", 1'b0, 1'b0});
    exp_q.push_back('{"P", 1'b0, 1'b0});
    case (c)
      0: begin ins.op = 6'd31;
        exp_q.push_back('{"X", 1'b0, 1'b0}); exp_q.push_back('{"W", 1'b0, 1'b0}); end
      1: begin ins.op = 6'(alu_i[$urandom_range(0, 4)]);
        exp_q.push_back('{"X", 1'b1, 1'b0}); exp_q.push_back('{"W", 1'b0, 1'b0}); end
      2: begin ins.op = 6'(ld[$urandom_range(0, 3)]);
        exp_q.push_back('{"X", 1'b1, 1'b0}); exp_q.push_back('{"M", 1'b1, 1'b0});
        exp_q.push_back('{"W", 1'b1, 1'b0}); end
      3: begin ins.op = 6'(st[$urandom_range(0, 3)]);
        exp_q.push_back('{"X", 1'b1, 1'b0}); exp_q.push_back('{"M", 1'b1, 1'b1}); end
      4: begin ins.op = 6'd18;
        exp_q.push_back('{"X", 1'b0, 1'b0}); exp_q.push_back('{"P", 1'b1, 1'b0}); end
      5: begin ins.op = 6'd16;
        exp_q.push_back('{"X", 1'b0, 1'b0});
        if (ins.taken) exp_q.push_back('{"P", 1'b1, 1'b0}); end
      default: ins.op = 6'd17;
    endcase
  endtask

  initial begin
    instr_t ins;
    int n_prog = 30, idx = 0, cyc = 0, zeros = 0;
    logic irw, h, done;
    logic [2:0] trace[5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};

    opcode = 6'd0; branch_taken = 1'b0; mem_ready = 1'b0;
    do_reset();
    @(negedge clock);
    check("reset_state", 32'(a_state), 0);
    check("reset_count", a_count, 0);
    check("reset_flags", {a_halted, a_illegal, a_bus_error, a_mem_req}, 0);

    // random program ending in SYS
    for (int i = 0; i < n_prog - 1; i++) begin
      gen_instr(int'($urandom_range(0, 5)), ins);
      prog.push_back(ins);
    end
    gen_instr(6, ins);
    prog.push_back(ins);

    mon_en = 1'b1;
    tick();
    start = 1'b1; mem_ready = 1'b1;
    done = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge clock);
      irw = a_ir_write; h = a_halted;
      tick();
      cyc++;
      start = 1'b0;
      if (irw && idx < prog.size()) begin
        opcode = prog[idx].op; branch_taken = prog[idx].taken; idx++;
      end
      if (zeros >= 4) mem_ready = 1'b1;
      else mem_ready = ($urandom_range(0, 2) != 0);
      zeros = mem_ready ? 0 : zeros + 1;
      if (h) done = 1'b1;
    end
    check("random_run_done", 32'(done), 1);
    @(negedge clock);
    mon_en = 1'b0;
    check("events_left", exp_q.size(), 0);
    check("sys_halt_state", 32'(a_state), 6);
    check("retired_count", a_count, n_prog);
    check("saturated_count", 32'(b_count), (n_prog > 15) ? 15 : n_prog);
    check("random_flags", {a_illegal, a_bus_error}, 0);

    // ALU state trace with zero-wait memory
    do_reset();
    opcode = 6'd31; mem_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check("alu_trace_state", 32'(a_state), 32'(trace[k]));
      if (k == 3) check("alu_wb", {a_reg_write, a_mem_to_reg}, 2'b10);
      tick();
    end
    check("alu_count", a_count, 1);

    // illegal opcode halts, start ignored, reset clears
    do_reset();
    opcode = 6'd0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    check("illegal_state", 32'(a_state), 6);
    check("illegal_flags", {a_halted, a_illegal, a_bus_error}, 3'b110);
    check("illegal_count", a_count, 0);
    start = 1'b1; tick(); start = 1'b0; tick();
    check("halt_ignores_start", 32'(a_state), 6);
    do_reset();
    @(negedge clock);
    check("reset_clears", {a_state, a_halted, a_illegal}, 0);

    // fetch timeout: 16 cycles without mem_ready
    opcode = 6'd31; mem_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    @(negedge clock);
    check("timeout_still_fetch", {a_state, a_mem_req}, {3'd1, 1'b1});
    tick();
    check("timeout_halt", {a_state, a_bus_error, a_halted}, {3'd6, 1'b1, 1'b1});

    // mem_ready on exactly the 16th cycle wins
    do_reset();
    mem_ready = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    mem_ready = 1'b1;
    @(negedge clock);
    check("boundary_ir_write", 32'(a_ir_write), 1);
    tick();
    check("boundary_decode", {a_state, a_bus_error}, {3'd2, 1'b0});

    // reset mid-MEMORY drops mem_req
    do_reset();
    opcode = 6'd32; mem_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    @(negedge clock);
    check("load_mem_req", {a_state, a_mem_req, a_mem_addr_sel, a_mem_we}, {3'd4, 3'b110});
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clock);
    check("mid_mem_reset", {a_state, a_mem_req}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
